// File: rtl/timer_counter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : timer_counter_if
//  Description : Word-address / byte-enable store bus between the system
//                bridge and the programmable timer, plus the irq line.
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_counter_if;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr,
        output byteen,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  byteen,
        input  wdata,
        output rdata,
        output irq
    );
endinterface
`default_nettype wire

// File: rtl/timer_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : timer_counter
//  Description : Memory-mapped down-counting timer with one-shot or
//                auto-reload expiry, maskable interrupt request to the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);

    localparam logic [1:0] c_OFF_CTRL   = 2'd0;
    localparam logic [1:0] c_OFF_PRESET = 2'd1;
    localparam logic [1:0] c_OFF_COUNT  = 2'd2;
    localparam logic [1:0] c_MODE_AUTO  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic [31:0] w_count_next;
    logic        r_flag;

    logic        w_sel;
    logic [1:0]  w_off;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en;
    logic [1:0]  w_mode;
    logic        w_im;
    logic        w_flag_set;
    logic        w_flag_clr_fsm;
    logic        w_en_clr;
    logic        w_ack;
    logic        w_unused_addr;

    assign w_sel          = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign w_off          = bus.addr[3:2];
    assign w_unused_addr  = &{1'b0, bus.addr[1:0]};
    assign w_wr_ctrl      = w_sel && (|bus.byteen) && (w_off == c_OFF_CTRL);
    assign w_wr_preset    = w_sel && (|bus.byteen) && (w_off == c_OFF_PRESET);

    assign w_en   = r_ctrl[0];
    assign w_mode = r_ctrl[2:1];
    assign w_im   = r_ctrl[3];

    // A CPU write acknowledges only a visible interrupt; a masked pending
    // flag survives so that unmasking later still raises irq.
    assign w_ack  = (w_wr_ctrl || w_wr_preset) && w_im;

    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_flag_set     = 1'b0;
        w_flag_clr_fsm = 1'b0;
        w_en_clr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_en) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_next = r_preset;
                w_state_next = S_CNT;
            end
            S_CNT: begin
                if (!w_en) begin
                    w_state_next = S_IDLE;
                end else if (r_count > 32'd1) begin
                    w_count_next = r_count - 32'd1;
                end else begin
                    // PRESET of 0 lands here too, so it expires like PRESET=1
                    w_count_next = 32'd0;
                    w_flag_set   = 1'b1;
                    w_state_next = S_INT;
                end
            end
            S_INT: begin
                if (w_mode == c_MODE_AUTO) begin
                    w_flag_clr_fsm = 1'b1;
                    w_state_next   = S_LOAD;
                end else begin
                    w_en_clr     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ctrl   <= 4'd0;
            r_preset <= 32'd0;
            r_count  <= 32'd0;
            r_flag   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;

            // A CPU write to CTRL overrides the FSM's own EN clear
            if (w_wr_ctrl && bus.byteen[0]) begin
                r_ctrl <= bus.wdata[3:0];
            end else if (w_en_clr) begin
                r_ctrl[0] <= 1'b0;
            end

            for (int b = 0; b < 4; b++) begin
                if (w_wr_preset && bus.byteen[b]) begin
                    r_preset[8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end

            if (w_flag_set) begin
                r_flag <= 1'b1;
            end else if (w_flag_clr_fsm || w_ack) begin
                r_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        if (w_sel) begin
            case (w_off)
                c_OFF_CTRL:   bus.rdata = {28'd0, r_ctrl};
                c_OFF_PRESET: bus.rdata = r_preset;
                c_OFF_COUNT:  bus.rdata = r_count;
                default:      bus.rdata = 32'd0;
            endcase
        end
    end

    assign bus.irq = w_im & r_flag;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_timer_counter
//  Description : Self-checking bench for timer_counter; per-cycle COUNT/irq
//                expectations are queued and popped as the timer advances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_counter;

    localparam logic [31:0] c_BASE   = 32'h0000_7F00;
    localparam logic [31:0] c_CTRL   = c_BASE + 32'd0;
    localparam logic [31:0] c_PRESET = c_BASE + 32'd4;
    localparam logic [31:0] c_COUNT  = c_BASE + 32'd8;
    localparam logic [31:0] c_RSVD   = c_BASE + 32'd12;
    localparam logic [31:0] c_NEXT   = c_BASE + 32'd16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    timer_counter_if bus();

    timer_counter #(.BASE_ADDR(c_BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [31:0] count;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic bus_idle();
        bus.addr   = c_COUNT;
        bus.byteen = 4'h0;
        bus.wdata  = 32'd0;
    endtask

    // Advance one edge; leave the bus idle pointing at COUNT for sampling
    task automatic tick();
        @(posedge clk);
        #1;
        bus_idle();
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.addr   = a;
        bus.byteen = be;
        bus.wdata  = d;
        tick();
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
        bus.addr   = a;
        bus.byteen = 4'h0;
        #1;
        d = bus.rdata;
    endtask

    task automatic expect_cycle(input logic [31:0] c, input logic i);
        sb_q.push_back(exp_t'({c, i}));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Pop one expectation per edge; optionally inject a full-word write at edge wr_idx
    task automatic drain(input string name, input int wr_idx,
                         input logic [31:0] wr_addr, input logic [31:0] wr_data);
        exp_t e;
        int   idx;
        idx = 0;
        while (sb_q.size() > 0) begin
            if (idx == wr_idx) begin
                bus.addr   = wr_addr;
                bus.byteen = 4'hF;
                bus.wdata  = wr_data;
            end
            tick();
            e = sb_q.pop_front();
            n_checks++;
            if (bus.rdata !== e.count || bus.irq !== e.irq) begin
                n_fail++;
                $display("FAIL %s edge E%0d: count=%h irq=%b, required count=%h irq=%b",
                         name, idx + 1, bus.rdata, bus.irq, e.count, e.irq);
            end
            idx++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        cpu_write(c_PRESET, 4'hF, 32'd5);
        cpu_write(c_CTRL, 4'hF, 32'h9);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: irq=%b, required 0", bus.irq);
        end
        read_reg(c_COUNT, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL reset_count: got %h, required 0", rd);
        end
        read_reg(c_CTRL, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h, required 0", rd);
        end
        repeat (3) expect_cycle(32'd0, 1'b0);
        drain("reset_idle", -1, 32'd0, 32'd0);
    endtask

    task automatic test_one_shot();
        logic [31:0] rd;
        do_reset();
        cpu_write(c_PRESET, 4'hF, 32'd3);
        cpu_write(c_CTRL, 4'hF, 32'h9);
        expect_cycle(32'd0, 1'b0);
        expect_cycle(32'd3, 1'b0);
        expect_cycle(32'd2, 1'b0);
        expect_cycle(32'd1, 1'b0);
        expect_cycle(32'd0, 1'b1);
        expect_cycle(32'd0, 1'b1);
        expect_cycle(32'd0, 1'b1);
        drain("one_shot", -1, 32'd0, 32'd0);
        read_reg(c_CTRL, rd);
        n_checks++;
        if (rd !== 32'h8) begin
            n_fail++; $display("FAIL one_shot_en_clear: ctrl=%h, required 00000008", rd);
        end
        cpu_write(c_CTRL, 4'hF, 32'h0);
        n_checks++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL one_shot_ack: irq=%b, required 0", bus.irq);
        end
    endtask

    task automatic test_auto_reload();
        do_reset();
        cpu_write(c_PRESET, 4'hF, 32'd2);
        cpu_write(c_CTRL, 4'hF, 32'hB);
        expect_cycle(32'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            expect_cycle(32'd2, 1'b0);
            expect_cycle(32'd1, 1'b0);
            expect_cycle(32'd0, 1'b1);
            expect_cycle(32'd0, 1'b0);
        end
        expect_cycle(32'd2, 1'b0);
        drain("auto_reload", -1, 32'd0, 32'd0);
    endtask

    task automatic test_mask();
        logic [31:0] rd;
        do_reset();
        cpu_write(c_PRESET, 4'hF, 32'd1);
        cpu_write(c_CTRL, 4'hF, 32'h1);
        expect_cycle(32'd0, 1'b0);
        expect_cycle(32'd1, 1'b0);
        expect_cycle(32'd0, 1'b0);
        expect_cycle(32'd0, 1'b0);
        drain("mask", -1, 32'd0, 32'd0);
        read_reg(c_CTRL, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL mask_ctrl: ctrl=%h, required 0", rd);
        end
        cpu_write(c_CTRL, 4'hF, 32'h8);
        n_checks++;
        if (bus.irq !== 1'b1) begin
            n_fail++; $display("FAIL mask_unmask: irq=%b, required 1", bus.irq);
        end
        cpu_write(c_PRESET, 4'hF, 32'd7);
        n_checks++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL mask_preset_ack: irq=%b, required 0", bus.irq);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        do_reset();
        cpu_write(c_PRESET, 4'hF, 32'h1122_3344);
        cpu_write(c_PRESET, 4'h1, 32'hAABB_CCDD);
        read_reg(c_PRESET, rd);
        n_checks++;
        if (rd !== 32'h1122_33DD) begin
            n_fail++; $display("FAIL lane0: preset=%h, required 112233dd", rd);
        end
        cpu_write(c_PRESET, 4'h4, 32'hAABB_CCDD);
        read_reg(c_PRESET, rd);
        n_checks++;
        if (rd !== 32'h11BB_33DD) begin
            n_fail++; $display("FAIL lane2: preset=%h, required 11bb33dd", rd);
        end
        cpu_write(c_COUNT, 4'hF, 32'hFFFF_FFFF);
        read_reg(c_COUNT, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL count_ro: count=%h, required 0", rd);
        end
        cpu_write(c_NEXT, 4'hF, 32'h0000_000F);
        cpu_write(c_RSVD, 4'hF, 32'h0000_000F);
        read_reg(c_CTRL, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL decode_ctrl: ctrl=%h, required 0", rd);
        end
        read_reg(c_NEXT, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL unselected_rdata: rdata=%h, required 0", rd);
        end
        read_reg(c_RSVD, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL reserved_rdata: rdata=%h, required 0", rd);
        end
    endtask

    task automatic test_edge();
        do_reset();
        cpu_write(c_PRESET, 4'hF, 32'd0);
        cpu_write(c_CTRL, 4'hF, 32'h9);
        expect_cycle(32'd0, 1'b0);
        expect_cycle(32'd0, 1'b0);
        expect_cycle(32'd0, 1'b1);
        expect_cycle(32'd0, 1'b1);
        drain("preset_zero", -1, 32'd0, 32'd0);

        do_reset();
        cpu_write(c_PRESET, 4'hF, 32'd4);
        cpu_write(c_CTRL, 4'hF, 32'hB);
        expect_cycle(32'd0, 1'b0);
        expect_cycle(32'd4, 1'b0);
        expect_cycle(32'd3, 1'b0);
        expect_cycle(32'd2, 1'b0);
        expect_cycle(32'd1, 1'b0);
        expect_cycle(32'd0, 1'b1);
        expect_cycle(32'd0, 1'b0);
        expect_cycle(32'd2, 1'b0);
        expect_cycle(32'd1, 1'b0);
        expect_cycle(32'd0, 1'b1);
        // PRESET rewritten at E4 while counting: only the next reload sees it
        drain("preset_midcount", 3, c_PRESET, 32'd2);
    endtask

    initial begin
        bus_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_mask();
        test_byte_lanes();
        test_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
